// File: rtl/mem0_pkg.sv
// Shared mem0 AXI4 constants, default widths and AR stage state type.
// Latency: none (package).
// Backpressure: n/a; reused by the read and write arbiters.
package mem0_pkg;

  localparam int MEM0_ADDR_W = 64;
  localparam int MEM0_DATA_W = 512;
  localparam int MEM0_ID_W   = 6;

  localparam logic [2:0] AXI_SIZE_64B      = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic       AXI_LOCK_NORMAL   = 1'b0;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
  localparam logic [3:0] AXI_QOS_DEFAULT   = 4'b0000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ar_stage_e;

  // Outstanding-burst counter update: simultaneous inc/dec cancel out,
  // and a stray decrement at zero is ignored rather than wrapping.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt,
                                          input logic       inc,
                                          input logic       dec);
    logic [7:0] n;
    n = cnt;
    if (inc && !dec) begin
      n = cnt + 8'd1;
    end else if (dec && !inc && (cnt != 8'd0)) begin
      n = cnt - 8'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mem0_rd_arbiter_if.sv
// Requester-side and mem0-side read channel bundles for the read arbiter.
// Latency: none (wiring only).
// Backpressure: AR valid/ready and R valid/ready carried per bundle.
interface mem0_req_if
  import mem0_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = MEM0_ADDR_W,
  parameter int DATA_W = MEM0_DATA_W
) ();

  logic [NREQ-1:0]        req_arvalid;
  logic [NREQ-1:0]        req_arready;
  logic [NREQ*ADDR_W-1:0] req_araddr;
  logic [NREQ*8-1:0]      req_arlen;
  logic [NREQ-1:0]        req_rvalid;
  logic [NREQ-1:0]        req_rready;
  logic [DATA_W-1:0]      req_rdata;
  logic                   req_rlast;
  logic [1:0]             req_rresp;

  // Read engines side.
  modport master (
    output req_arvalid, req_araddr, req_arlen, req_rready,
    input  req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
  );

  // Arbiter side.
  modport slave (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
    output req_arready, req_rvalid, req_rdata, req_rlast, req_rresp
  );

endinterface

interface mem0_axi_rd_if
  import mem0_pkg::*;
#(
  parameter int ADDR_W = MEM0_ADDR_W,
  parameter int DATA_W = MEM0_DATA_W,
  parameter int ID_W   = MEM0_ID_W
) ();

  logic              mem0_ARVALID;
  logic              mem0_ARREADY;
  logic [ADDR_W-1:0] mem0_ARADDR;
  logic [7:0]        mem0_ARLEN;
  logic [ID_W-1:0]   mem0_ARID;
  logic [2:0]        mem0_ARSIZE;
  logic [1:0]        mem0_ARBURST;
  logic              mem0_ARLOCK;
  logic [3:0]        mem0_ARCACHE;
  logic [2:0]        mem0_ARPROT;
  logic [3:0]        mem0_ARQOS;
  logic              mem0_RVALID;
  logic              mem0_RREADY;
  logic [DATA_W-1:0] mem0_RDATA;
  logic [ID_W-1:0]   mem0_RID;
  logic              mem0_RLAST;
  logic [1:0]        mem0_RRESP;

  // Arbiter side (AXI master).
  modport master (
    output mem0_ARVALID, mem0_ARADDR, mem0_ARLEN, mem0_ARID, mem0_ARSIZE,
           mem0_ARBURST, mem0_ARLOCK, mem0_ARCACHE, mem0_ARPROT, mem0_ARQOS,
           mem0_RREADY,
    input  mem0_ARREADY, mem0_RVALID, mem0_RDATA, mem0_RID, mem0_RLAST,
           mem0_RRESP
  );

  // Memory / wrapper side (AXI slave).
  modport slave (
    input  mem0_ARVALID, mem0_ARADDR, mem0_ARLEN, mem0_ARID, mem0_ARSIZE,
           mem0_ARBURST, mem0_ARLOCK, mem0_ARCACHE, mem0_ARPROT, mem0_ARQOS,
           mem0_RREADY,
    output mem0_ARREADY, mem0_RVALID, mem0_RDATA, mem0_RID, mem0_RLAST,
           mem0_RRESP
  );

endinterface

// File: rtl/mem0_rd_arbiter_rr_arbiter.sv
// Round-robin one-hot grant among N requests, priority after last grant.
// Latency: combinational grant; pointer moves on the accepting clock edge.
// Backpressure: pointer only advances when the grant is accepted.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_accept,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_last;
  logic [N-1:0]     w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan requests starting just after the last winner, wrapping mod N.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      automatic int               t = int'(r_last) + off;
      automatic logic [IDX_W-1:0] k;
      if (t >= N) t = t - N;
      k = IDX_W'(t);
      if (!w_found && i_req[k]) begin
        w_found  = 1'b1;
        w_gnt[k] = 1'b1;
        w_idx    = k;
      end
    end
  end

  // Remember the accepted winner; reset value gives index 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= IDX_W'(N - 1);
    end else if (i_accept && w_found) begin
      r_last <= w_idx;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/mem0_rd_arbiter.sv
// Shares mem0 AR/R among NREQ read engines; ARID = requester, R routed by RID.
// Latency: AR handshake -> mem0_ARVALID next cycle; R path combinational.
// Backpressure: one-entry AR stage holds on !ARREADY; R stalls per RID's rready.
module mem0_rd_arbiter
  import mem0_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = MEM0_ADDR_W,
  parameter int DATA_W  = MEM0_DATA_W,
  parameter int ID_W    = MEM0_ID_W,
  parameter int MAX_OUT = 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  mem0_req_if.slave     req,
  mem0_axi_rd_if.master mem0,
  output logic          rid_err
);

  localparam int         IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

  // AR stage and bookkeeping state
  ar_stage_e         r_state;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [ID_W-1:0]   r_arid;
  logic [7:0]        r_out_cnt [NREQ];
  logic              r_rid_err;

  logic              w_slot_free;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_arb_req;
  logic [NREQ-1:0]   w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [7:0]        w_sel_len;
  logic [ID_W-1:0]   w_sel_id;
  logic [NREQ-1:0]   w_rid_hit;
  logic              w_rid_ok;
  logic              w_rid_rdy;
  logic              w_rready;
  logic [NREQ-1:0]   w_dec;

  // Slot can take a new burst if empty or its current burst leaves now.
  assign w_slot_free = (r_state == ST_EMPTY) || mem0.mem0_ARREADY;

  // Requesters at their outstanding cap drop out; nothing is granted in reset.
  always_comb begin
    w_elig    = '0;
    w_arb_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req.req_arvalid[i] && (r_out_cnt[i] < MAX_CNT);
    end
    if (ap_rst_n && w_slot_free) begin
      w_arb_req = w_elig;
    end
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .i_req     (w_arb_req),
    .i_accept  (w_accept),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // A grant is a handshake: arready is the grant and arvalid is already high.
  assign w_accept        = |w_gnt;
  assign req.req_arready = w_gnt;

  // Pick the winner's address/length slice; ARID is its zero-extended index.
  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_id   = '0;
    w_sel_id[IDX_W-1:0] = w_gnt_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req.req_araddr[i*ADDR_W +: ADDR_W];
        w_sel_len  = req.req_arlen[i*8 +: 8];
      end
    end
  end

  // One-entry AR output stage: load on grant, drain on ARREADY.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state   <= ST_EMPTY;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arid    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state   <= ST_FULL;
            r_arvalid <= 1'b1;
            r_araddr  <= w_sel_addr;
            r_arlen   <= w_sel_len;
            r_arid    <= w_sel_id;
          end
        end
        ST_FULL: begin
          if (mem0.mem0_ARREADY) begin
            if (w_accept) begin
              r_araddr <= w_sel_addr;
              r_arlen  <= w_sel_len;
              r_arid   <= w_sel_id;
            end else begin
              r_state   <= ST_EMPTY;
              r_arvalid <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

  assign mem0.mem0_ARVALID = r_arvalid;
  assign mem0.mem0_ARADDR  = r_araddr;
  assign mem0.mem0_ARLEN   = r_arlen;
  assign mem0.mem0_ARID    = r_arid;
  assign mem0.mem0_ARSIZE  = AXI_SIZE_64B;
  assign mem0.mem0_ARBURST = AXI_BURST_INCR;
  assign mem0.mem0_ARLOCK  = AXI_LOCK_NORMAL;
  assign mem0.mem0_ARCACHE = AXI_CACHE_DEFAULT;
  assign mem0.mem0_ARPROT  = AXI_PROT_DEFAULT;
  assign mem0.mem0_ARQOS   = AXI_QOS_DEFAULT;

  // Decode RID; an ID matching no requester leaves w_rid_hit all zero.
  always_comb begin
    w_rid_hit = '0;
    w_rid_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (mem0.mem0_RID == ID_W'(i)) begin
        w_rid_hit[i] = 1'b1;
        w_rid_rdy    = req.req_rready[i];
      end
    end
  end

  assign w_rid_ok = |w_rid_hit;
  // Unknown IDs are accepted and dropped so the R channel never wedges.
  assign w_rready = ap_rst_n && (w_rid_ok ? w_rid_rdy : 1'b1);

  assign mem0.mem0_RREADY = w_rready;
  assign req.req_rvalid   = (ap_rst_n && mem0.mem0_RVALID) ? w_rid_hit : '0;
  assign req.req_rdata    = mem0.mem0_RDATA;
  assign req.req_rlast    = mem0.mem0_RLAST;
  assign req.req_rresp    = mem0.mem0_RRESP;

  assign w_dec = (mem0.mem0_RVALID && w_rready && mem0.mem0_RLAST) ? w_rid_hit : '0;

  // Outstanding bursts: +1 on AR grant, -1 on the burst's last R beat.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        r_out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        r_out_cnt[i] <= cnt_next(r_out_cnt[i], w_gnt[i], w_dec[i]);
      end
    end
  end

  // Sticky flag for any beat whose RID maps to no requester.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_rid_err <= 1'b0;
    end else if (mem0.mem0_RVALID && !w_rid_ok) begin
      r_rid_err <= 1'b1;
    end
  end

  assign rid_err = r_rid_err;

endmodule

// File: tb/tb_mem0_rd_arbiter.sv
// Directed bench for mem0_rd_arbiter: AR arbitration, stall, cap, R routing.
// Latency: inputs driven 1 time unit after posedge, checked 1 unit later.
// Backpressure: ARREADY / req_rready patterns are hand-scripted per test.
module tb_mem0_rd_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 6;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic rid_err;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem0_req_if    #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_bus ();
  mem0_axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) mem0_bus ();

  mem0_rd_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W),
    .MAX_OUT (8)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req      (req_bus),
    .mem0     (mem0_bus),
    .rid_err  (rid_err)
  );

  always #5 ap_clk = ~ap_clk;

  // R beat table: rid, data, last, per-requester rready, expected RREADY/rvalid.
  logic [5:0] t_rid  [7] = '{6'd3, 6'd3, 6'd3, 6'd0, 6'd3, 6'd3, 6'd3};
  logic [7:0] t_dat  [7] = '{8'h30, 8'h30, 8'h30, 8'h0A, 8'h31, 8'h32, 8'h33};
  logic       t_last [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] t_rrdy [7] = '{4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
  logic       t_xrdy [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] t_xvld [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b1000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    req_bus.req_arvalid   = '0;
    mem0_bus.mem0_RVALID  = 1'b0;
    step();
    step();
    ap_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0;
    req_bus.req_arvalid   = 4'hF;
    req_bus.req_rready    = 4'hF;
    req_bus.req_araddr    = '0;
    req_bus.req_arlen     = '0;
    mem0_bus.mem0_ARREADY = 1'b1;
    mem0_bus.mem0_RVALID  = 1'b1;
    mem0_bus.mem0_RID     = 6'd1;
    mem0_bus.mem0_RDATA   = '0;
    mem0_bus.mem0_RLAST   = 1'b0;
    mem0_bus.mem0_RRESP   = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      req_bus.req_araddr[i*ADDR_W +: ADDR_W] = 64'hA000 + 64'(i) * 64'h100;
      req_bus.req_arlen[i*8 +: 8]            = 8'(i + 3);
    end

    // Reset state, with requests and an R beat present.
    step();
    step();
    #1;
    check_eq("rst_arready", 64'(req_bus.req_arready), 64'h0);
    check_eq("rst_rvalid",  64'(req_bus.req_rvalid), 64'h0);
    check_eq("rst_rready",  64'(mem0_bus.mem0_RREADY), 64'h0);
    check_eq("rst_arvalid", 64'(mem0_bus.mem0_ARVALID), 64'h0);
    check_eq("rst_araddr",  mem0_bus.mem0_ARADDR, 64'h0);
    check_eq("rst_arlen",   64'(mem0_bus.mem0_ARLEN), 64'h0);
    check_eq("rst_arid",    64'(mem0_bus.mem0_ARID), 64'h0);
    check_eq("rst_rid_err", 64'(rid_err), 64'h0);
    check_eq("const_fields", {45'h0, mem0_bus.mem0_ARSIZE, mem0_bus.mem0_ARBURST,
             mem0_bus.mem0_ARLOCK, mem0_bus.mem0_ARCACHE, mem0_bus.mem0_ARPROT,
             mem0_bus.mem0_ARQOS}, {45'h0, 3'b110, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
    req_bus.req_arvalid  = '0;
    mem0_bus.mem0_RVALID = 1'b0;

    // Test 1: requesters 0 and 2 -> grants 0 then 2.
    ap_rst_n = 1'b1;
    req_bus.req_arvalid = 4'b0101;
    #1;
    check_eq("t1_gnt0", 64'(req_bus.req_arready), 64'b0001);
    check_eq("t1_arvalid_lo", 64'(mem0_bus.mem0_ARVALID), 64'h0);
    step();
    req_bus.req_arvalid = 4'b0100;
    #1;
    check_eq("t1_gnt2", 64'(req_bus.req_arready), 64'b0100);
    check_eq("t1_arvalid0", 64'(mem0_bus.mem0_ARVALID), 64'h1);
    check_eq("t1_arid0", 64'(mem0_bus.mem0_ARID), 64'h0);
    check_eq("t1_araddr0", mem0_bus.mem0_ARADDR, 64'hA000);
    check_eq("t1_arlen0", 64'(mem0_bus.mem0_ARLEN), 64'h3);
    step();
    req_bus.req_arvalid = 4'b0000;
    #1;
    check_eq("t1_arvalid2", 64'(mem0_bus.mem0_ARVALID), 64'h1);
    check_eq("t1_arid2", 64'(mem0_bus.mem0_ARID), 64'h2);
    check_eq("t1_araddr2", mem0_bus.mem0_ARADDR, 64'hA200);
    check_eq("t1_arlen2", 64'(mem0_bus.mem0_ARLEN), 64'h5);
    check_eq("t1_no_gnt", 64'(req_bus.req_arready), 64'h0);
    step();
    #1;
    check_eq("t1_drained", 64'(mem0_bus.mem0_ARVALID), 64'h0);

    // Test 2: all four continuously -> 0,1,2,3,0,1,2,3 without gaps.
    do_reset();
    mem0_bus.mem0_ARREADY = 1'b1;
    req_bus.req_arvalid   = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq("t2_gnt", 64'(req_bus.req_arready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check_eq("t2_arid", 64'(mem0_bus.mem0_ARID), 64'((k - 1) % 4));
        check_eq("t2_arvalid", 64'(mem0_bus.mem0_ARVALID), 64'h1);
      end
      step();
      #1;
    end
    check_eq("t2_arid_last", 64'(mem0_bus.mem0_ARID), 64'h3);
    req_bus.req_arvalid = '0;

    // Test 3: stage FULL, ARREADY low for 5 cycles.
    do_reset();
    mem0_bus.mem0_ARREADY = 1'b0;
    req_bus.req_arvalid   = 4'b0011;
    #1;
    check_eq("t3_gnt0", 64'(req_bus.req_arready), 64'b0001);
    step();
    req_bus.req_arvalid = 4'b0010;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_hold_gnt", 64'(req_bus.req_arready), 64'h0);
      check_eq("t3_hold_vld", 64'(mem0_bus.mem0_ARVALID), 64'h1);
      check_eq("t3_hold_id", 64'(mem0_bus.mem0_ARID), 64'h0);
      check_eq("t3_hold_addr", mem0_bus.mem0_ARADDR, 64'hA000);
      check_eq("t3_hold_len", 64'(mem0_bus.mem0_ARLEN), 64'h3);
      step();
      #1;
    end
    mem0_bus.mem0_ARREADY = 1'b1;
    #1;
    check_eq("t3_resume_gnt", 64'(req_bus.req_arready), 64'b0010);
    step();
    req_bus.req_arvalid = '0;
    #1;
    check_eq("t3_resume_id", 64'(mem0_bus.mem0_ARID), 64'h1);
    check_eq("t3_resume_addr", mem0_bus.mem0_ARADDR, 64'hA100);

    // Test 4: requester 1 reaches 8 outstanding, then one RLAST frees it.
    do_reset();
    mem0_bus.mem0_ARREADY = 1'b1;
    req_bus.req_arvalid   = 4'b0010;
    #1;
    for (int c = 0; c < 8; c++) begin
      check_eq("t4_fill", 64'(req_bus.req_arready), 64'b0010);
      step();
      #1;
    end
    check_eq("t4_capped", 64'(req_bus.req_arready), 64'h0);
    req_bus.req_arvalid = 4'b1010;
    #1;
    check_eq("t4_other_served", 64'(req_bus.req_arready), 64'b1000);
    step();
    req_bus.req_arvalid = 4'b0010;
    #1;
    check_eq("t4_still_capped", 64'(req_bus.req_arready), 64'h0);
    mem0_bus.mem0_RVALID = 1'b1;
    mem0_bus.mem0_RID    = 6'd1;
    mem0_bus.mem0_RLAST  = 1'b1;
    req_bus.req_rready   = 4'b0010;
    #1;
    check_eq("t4_r_vld", 64'(req_bus.req_rvalid), 64'b0010);
    check_eq("t4_r_rdy", 64'(mem0_bus.mem0_RREADY), 64'h1);
    check_eq("t4_cap_same_cycle", 64'(req_bus.req_arready), 64'h0);
    step();
    mem0_bus.mem0_RVALID = 1'b0;
    mem0_bus.mem0_RLAST  = 1'b0;
    #1;
    check_eq("t4_regrant", 64'(req_bus.req_arready), 64'b0010);
    step();
    req_bus.req_arvalid = '0;
    #1;
    check_eq("t4_regrant_id", 64'(mem0_bus.mem0_ARID), 64'h1);

    // Test 5: interleaved R beats for requesters 3 and 0.
    for (int k = 0; k < 7; k++) begin
      mem0_bus.mem0_RVALID = 1'b1;
      mem0_bus.mem0_RID    = t_rid[k];
      mem0_bus.mem0_RDATA  = {504'h0, t_dat[k]};
      mem0_bus.mem0_RLAST  = t_last[k];
      mem0_bus.mem0_RRESP  = 2'(k);
      req_bus.req_rready   = t_rrdy[k];
      #1;
      check_eq("t5_rready", 64'(mem0_bus.mem0_RREADY), 64'(t_xrdy[k]));
      check_eq("t5_rvalid", 64'(req_bus.req_rvalid), 64'(t_xvld[k]));
      check_eq("t5_rdata", req_bus.req_rdata[63:0], 64'(t_dat[k]));
      check_eq("t5_rlast", 64'(req_bus.req_rlast), 64'(t_last[k]));
      check_eq("t5_rresp", 64'(req_bus.req_rresp), 64'(k % 4));
      step();
    end
    mem0_bus.mem0_RVALID = 1'b0;

    // Test 6: RID outside the requester range.
    mem0_bus.mem0_RVALID = 1'b1;
    mem0_bus.mem0_RID    = 6'd7;
    mem0_bus.mem0_RLAST  = 1'b1;
    req_bus.req_rready   = 4'b0000;
    #1;
    check_eq("t6_drop_rdy", 64'(mem0_bus.mem0_RREADY), 64'h1);
    check_eq("t6_no_vld", 64'(req_bus.req_rvalid), 64'h0);
    check_eq("t6_err_pre", 64'(rid_err), 64'h0);
    step();
    mem0_bus.mem0_RVALID = 1'b0;
    mem0_bus.mem0_RLAST  = 1'b0;
    #1;
    check_eq("t6_err_set", 64'(rid_err), 64'h1);
    step();
    step();
    step();
    #1;
    check_eq("t6_err_sticky", 64'(rid_err), 64'h1);
    do_reset();
    #1;
    check_eq("t6_err_cleared", 64'(rid_err), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
